// File: rtl/frog_pkg.sv
// -----------------------------------------------------------------------------
// frog_pkg
// Shared definitions for the frog board game sequencer:
//   game_state_t  - round state encoding (IDLE/PLAY/WIN/LOSE), 2 bits
//   NPOS_DEFAULT  - default number of lanes on the board
//   SCORE_MAX     - saturation value of the 8-bit score
//   cnt_width()   - register width needed to hold 0..max_val (at least 1 bit)
// -----------------------------------------------------------------------------
package frog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } game_state_t;

  localparam int         NPOS_DEFAULT = 19;
  localparam logic [7:0] SCORE_MAX    = 8'd255;

  // A zero-valued counter would need a zero-width register; keep one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/frog_down_cnt.sv
// -----------------------------------------------------------------------------
// frog_down_cnt
// Loadable down counter that holds at zero.
//   clk      in   clock
//   rst      in   asynchronous reset, active-low (count <- RST_VAL)
//   load     in   load load_val on the next edge (wins over dec)
//   load_val in W value to load
//   dec      in   decrement by one on the next edge, unless already zero
//   zero     out  count is zero
// -----------------------------------------------------------------------------
module frog_down_cnt
  import frog_pkg::*;
#(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= RST_VAL;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/frog_game_ctrl.sv
// -----------------------------------------------------------------------------
// frog_game_ctrl
// Round sequencer for the frog board: paces go/back moves, detects hazard
// and timeout deaths, tracks lives and score, and drives the one-hot frog
// position vector for the board driver.
//   clk         in        clock
//   rst         in        asynchronous reset, active-low
//   start       in        start / continue pulse
//   clear       in        synchronous return to IDLE (highest priority)
//   go_pulse    in        forward move request
//   back_pulse  in        backward move request
//   hazard      in  NPOS  obstacle per lane (end lanes are always safe)
//   frog        out NPOS  one-hot frog position
//   game_state  out 2     0=IDLE 1=PLAY 2=WIN 3=LOSE
//   lives       out 2     remaining lives
//   score       out 8     rounds won, saturating
//   hit         out 1     one-cycle pulse when a life is lost
// NPOS must not exceed 32 (position register is 5 bits).
// -----------------------------------------------------------------------------
module frog_game_ctrl
  import frog_pkg::*;
#(
  parameter int NPOS      = NPOS_DEFAULT,
  parameter int MOVE_GAP  = 4,
  parameter int ROUND_CYC = 1000,
  parameter int LIVES     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clear,
  input  logic            go_pulse,
  input  logic            back_pulse,
  input  logic [NPOS-1:0] hazard,
  output logic [NPOS-1:0] frog,
  output logic [1:0]      game_state,
  output logic [1:0]      lives,
  output logic [7:0]      score,
  output logic            hit
);

  localparam int TW = cnt_width(ROUND_CYC);
  localparam int GW = cnt_width(MOVE_GAP);

  localparam logic [TW-1:0]   TIMER_INIT = TW'(ROUND_CYC);
  localparam logic [GW-1:0]   GAP_INIT   = GW'(MOVE_GAP);
  localparam logic [4:0]      POS_GOAL   = 5'(NPOS - 1);
  localparam logic [1:0]      LIVES_INIT = 2'(LIVES);
  // End lanes are safe, so their hazard bits never count.
  localparam logic [NPOS-1:0] LANE_MASK  = ~(NPOS'(1) | (NPOS'(1) << (NPOS - 1)));

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_PLAY = ST_PLAY;
  localparam logic [1:0] S_WIN  = ST_WIN;
  localparam logic [1:0] S_LOSE = ST_LOSE;

  logic [1:0]      state_reg, state_next;
  logic [4:0]      pos_reg, pos_next;
  logic [NPOS-1:0] frog_reg, frog_next;
  logic [1:0]      lives_reg, lives_next;
  logic [7:0]      score_reg, score_next;
  logic            hit_reg, hit_next;

  logic            timer_zero, gap_zero;
  logic            in_play, hazard_hit, death, accept, enter_play;
  logic            timer_load, gap_load;
  logic [GW-1:0]   gap_val;

  assign in_play    = (state_reg == S_PLAY);
  // frog_reg is one-hot on pos_reg, so masking selects hazard[pos].
  assign hazard_hit = |(hazard & frog_reg & LANE_MASK);
  assign death      = in_play && (hazard_hit || timer_zero);
  assign accept     = in_play && !death && gap_zero && (go_pulse ^ back_pulse);
  assign enter_play = start && ((state_reg == S_IDLE) || (state_reg == S_WIN));

  // Round timer: reloads on every round entry and on each death, counts only
  // while playing, so it is frozen in WIN.
  assign timer_load = clear || enter_play || death;

  frog_down_cnt #(
    .W       (TW),
    .RST_VAL (TIMER_INIT)
  ) u_round_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (TIMER_INIT),
    .dec      (in_play),
    .zero     (timer_zero)
  );

  // Move gap: cleared on round entry/death/clear, armed by an accepted move,
  // free-running down to zero otherwise.
  assign gap_load = clear || enter_play || death || accept;
  assign gap_val  = (accept && !clear) ? GAP_INIT : '0;

  frog_down_cnt #(
    .W       (GW),
    .RST_VAL ('0)
  ) u_move_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_val),
    .dec      (1'b1),
    .zero     (gap_zero)
  );

  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    lives_next = lives_reg;
    score_next = score_reg;
    hit_next   = 1'b0;

    if (clear) begin
      state_next = S_IDLE;
      pos_next   = '0;
      lives_next = LIVES_INIT;
      score_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_next = S_PLAY;
            pos_next   = '0;
            lives_next = LIVES_INIT;
            score_next = '0;
          end
        end
        S_PLAY: begin
          if (death) begin
            hit_next = 1'b1;
            pos_next = '0;
            if (lives_reg <= 2'd1) begin
              lives_next = '0;
              state_next = S_LOSE;
            end else begin
              lives_next = lives_reg - 2'd1;
            end
          end else if (accept) begin
            if (go_pulse) begin
              pos_next = pos_reg + 5'd1;
              if (pos_next == POS_GOAL) begin
                state_next = S_WIN;
                score_next = (score_reg == SCORE_MAX) ? score_reg : score_reg + 8'd1;
              end
            end else if (pos_reg != '0) begin
              pos_next = pos_reg - 5'd1;
            end
          end
        end
        S_WIN: begin
          if (start) begin
            state_next = S_PLAY;
            pos_next   = '0;
          end
        end
        default: begin
          // LOSE: score stays visible until a start from IDLE clears it.
          if (start) begin
            state_next = S_IDLE;
          end
        end
      endcase
    end
  end

  // One-hot decode of the next position, registered alongside pos.
  for (genvar gi = 0; gi < NPOS; gi++) begin : g_onehot
    assign frog_next[gi] = (pos_next == 5'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      pos_reg   <= '0;
      frog_reg  <= NPOS'(1);
      lives_reg <= LIVES_INIT;
      score_reg <= '0;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      frog_reg  <= frog_next;
      lives_reg <= lives_next;
      score_reg <= score_next;
      hit_reg   <= hit_next;
    end
  end

  assign frog       = frog_reg;
  assign game_state = state_reg;
  assign lives      = lives_reg;
  assign score      = score_reg;
  assign hit        = hit_reg;

endmodule
